program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: receives a byte-stream program image (count, 4-byte
// instructions MSB first, XOR checksum), writes each instruction into program
// memory and releases the processor from reset only after a good checksum.
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 29
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_start,
  input  logic [7:0]         in_byte,
  input  logic               in_byte_valid,
  output logic               out_byte_ready,
  output logic               out_pm_wr_en,
  output logic [ADDR_W-1:0]  out_pm_wr_add,
  output logic [INSTR_W-1:0] out_pm_wr_instruction,
  output logic               out_cpu_rst,
  output logic               out_done,
  output logic               out_error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  // Running XOR checksum over every accepted stream byte.
  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  // The first byte of an instruction may only carry opcode bits [4:0].
  function automatic logic first_byte_bad(input logic [7:0] b);
    return (b[7:5] != 3'd0);
  endfunction

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [7:0]           csum_q, csum_d;
  logic [7:0]           left_q, left_d;      // instructions still to be written
  logic [1:0]           idx_q, idx_d;        // byte position inside an instruction
  logic [23:0]          shift_q, shift_d;    // first three bytes of an instruction
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_add_q, wr_add_d;
  logic [INSTR_W-1:0]   wr_instr_q, wr_instr_d;
  logic                 ready_q, ready_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 xfer_s;
  logic                 restart_s;
  logic [31:0]          word_s;

  assign xfer_s    = in_byte_valid & ready_q;
  assign restart_s = in_start & (state_q != ST_WRITE);
  assign word_s    = {shift_q, in_byte};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    csum_d     = csum_q;
    left_d     = left_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    wr_add_d   = wr_add_q;
    wr_instr_d = wr_instr_q;

    if (restart_s) begin
      // Start (or abort-and-restart) wins over any simultaneous transfer.
      state_d = ST_COUNT;
      addr_d  = ADDR_W'(0);
      csum_d  = 8'd0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (xfer_s) begin
            csum_d  = csum_update(csum_q, in_byte);
            left_d  = in_byte;
            idx_d   = 2'd0;
            state_d = (in_byte == 8'd0) ? ST_CHECK : ST_DATA;
          end else begin
            state_d = ST_COUNT;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            csum_d = csum_update(csum_q, in_byte);
            if ((idx_q == 2'd0) && first_byte_bad(in_byte)) begin
              state_d = ST_ERROR;
            end else if (idx_q == 2'd3) begin
              // Last byte: present the assembled word while in WRITE.
              idx_d      = 2'd0;
              wr_add_d   = addr_q;
              wr_instr_d = word_s[INSTR_W-1:0];
              state_d    = ST_WRITE;
            end else begin
              idx_d   = idx_q + 2'd1;
              shift_d = {shift_q[15:0], in_byte};
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_WRITE: begin
          addr_d  = addr_q + ADDR_W'(1);
          left_d  = left_q - 8'd1;
          state_d = (left_q == 8'd1) ? ST_CHECK : ST_DATA;
        end
        ST_CHECK: begin
          if (xfer_s) begin
            state_d = (in_byte == csum_q) ? ST_DONE : ST_ERROR;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_IDLE:  state_d = ST_IDLE;
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they align with it.
    ready_d   = (state_d == ST_COUNT) || (state_d == ST_DATA) || (state_d == ST_CHECK);
    wr_en_d   = (state_d == ST_WRITE);
    cpu_rst_d = (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_W'(0);
      csum_q     <= 8'd0;
      left_q     <= 8'd0;
      idx_q      <= 2'd0;
      shift_q    <= 24'd0;
      wr_en_q    <= 1'b0;
      wr_add_q   <= ADDR_W'(0);
      wr_instr_q <= INSTR_W'(0);
      ready_q    <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      csum_q     <= csum_d;
      left_q     <= left_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      wr_en_q    <= wr_en_d;
      wr_add_q   <= wr_add_d;
      wr_instr_q <= wr_instr_d;
      ready_q    <= ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // A reset arriving during WRITE suppresses that cycle's strobe.
  assign out_pm_wr_en          = wr_en_q & ~in_rst;
  assign out_pm_wr_add         = wr_add_q;
  assign out_pm_wr_instruction = wr_instr_q;
  assign out_byte_ready        = ready_q;
  assign out_cpu_rst           = cpu_rst_q;
  assign out_done              = done_q;
  assign out_error             = error_q;

endmodule
